// File: rtl/rs232_tx.sv
// RS-232 style serial transmitter: start bit, 8 data bits LSB first,
// optional parity bit, 1 or 2 stop bits. Every bit lasts CLKS_PER_BIT clocks.
//
// state  | meaning
// IDLE   | line at 1, waiting for start_flag
// START  | start bit (0) on the line
// DATA   | data bits, bit_idx selects the current bit
// PARITY | parity bit (only when PARITY_EN=1)
// STOP   | stop bit(s) at 1, end_flag on the very last cycle
module rs232_tx #(
  parameter int N_BIT_STOP   = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       start_flag,
  output logic       txd_out,
  output logic       busy,
  output logic       end_flag
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  // end_flag is registered, so it is raised one cycle before the final boundary
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]    LAST_STOP = 3'(N_BIT_STOP - 1);
  localparam logic          ODD_BIT   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          baud_wrap;

  assign baud_wrap = (baud_cnt == BAUD_LAST);

  // Frame sequencer with registered line, busy and end-of-frame outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      txd_out   <= 1'b1;
      busy      <= 1'b0;
      end_flag  <= 1'b0;
    end else begin
      end_flag <= 1'b0;
      case (state)
        IDLE: begin
          txd_out  <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (start_flag) begin
            shift_reg <= data_in;
            txd_out   <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd_out  <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                txd_out <= (^shift_reg) ^ ODD_BIT;
                state   <= PARITY;
              end else begin
                txd_out <= 1'b1;
                state   <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd_out <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd_out  <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          txd_out <= 1'b1;
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
            end_flag <= (bit_idx == LAST_STOP) && (baud_cnt == BAUD_PRE);
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_idx  <= '0;
          txd_out  <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_tx.sv
// Testbench for rs232_tx: four instances with different framing options,
// each frame compared cycle by cycle against a bit-position reference model.
module tb_rs232_tx;

  localparam int CPB = 16;
  localparam int NU  = 4;
  localparam int PE [NU] = '{0, 1, 1, 0};
  localparam int PO [NU] = '{0, 0, 1, 0};
  localparam int NS [NU] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       st    [NU];
  logic [7:0] dat   [NU];
  logic       txd_w [NU];
  logic       busy_w[NU];
  logic       end_w [NU];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    rs232_tx #(
      .N_BIT_STOP  (NS[g]),
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (PE[g]),
      .PARITY_ODD  (PO[g])
    ) dut (
      .clk_in    (clk),
      .rst_in    (rst_n),
      .data_in   (dat[g]),
      .start_flag(st[g]),
      .txd_out   (txd_w[g]),
      .busy      (busy_w[g]),
      .end_flag  (end_w[g])
    );
  end

  task automatic check(string tag, logic obs, logic exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  function automatic int frame_len(int u);
    return (9 + PE[u] + NS[u]) * CPB;
  endfunction

  // Line value in cycle k (1-based after the accepting edge): bit slot k-1 / CPB
  function automatic logic model_bit(logic [7:0] d, int u, int k);
    int slot;
    slot = (k - 1) / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (PE[u] != 0 && slot == 9) return (^d) ^ (PO[u] != 0);
    return 1'b1;
  endfunction

  // Called at a negedge; requests a frame and checks every cycle of it plus
  // the following idle cycle. inject_at>0 pulses a foreign request mid-frame.
  task automatic send_frame(int u, logic [7:0] d, bit hold, int inject_at);
    int len;
    len = frame_len(u);
    st[u]  = 1'b1;
    dat[u] = d;
    @(posedge clk);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (!hold) st[u] = 1'b0;
      dat[u] = 8'($urandom);
      if (inject_at > 0 && k == inject_at) begin
        st[u]  = 1'b1;
        dat[u] = 8'h0F;
      end
      check($sformatf("u%0d d=%h txd c%0d", u, d, k), txd_w[u], model_bit(d, u, k));
      check($sformatf("u%0d d=%h busy c%0d", u, d, k), busy_w[u], 1'b1);
      check($sformatf("u%0d d=%h end c%0d", u, d, k), end_w[u], (k == len));
    end
    if (!hold) st[u] = 1'b0;
    @(negedge clk);
    check($sformatf("u%0d idle txd", u), txd_w[u], 1'b1);
    check($sformatf("u%0d idle busy", u), busy_w[u], 1'b0);
    check($sformatf("u%0d idle end", u), end_w[u], 1'b0);
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      st[u]  = 1'b0;
      dat[u] = 8'h00;
    end

    // reset state, including a request presented while reset is held
    st[0] = 1'b1;
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      check($sformatf("rst u%0d txd", u), txd_w[u], 1'b1);
      check($sformatf("rst u%0d busy", u), busy_w[u], 1'b0);
      check($sformatf("rst u%0d end", u), end_w[u], 1'b0);
    end
    st[0] = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int u = 0; u < NU; u++)
      check($sformatf("post-rst u%0d txd", u), txd_w[u], 1'b1);

    // default framing, 0x55
    send_frame(0, 8'h55, 1'b0, 0);
    // parity even / odd on 0xA3
    send_frame(1, 8'hA3, 1'b0, 0);
    send_frame(2, 8'hA3, 1'b0, 0);
    // two stop bits on 0x00
    send_frame(3, 8'h00, 1'b0, 0);
    // foreign request at cycle 40 must be ignored
    send_frame(0, 8'h55, 1'b0, 40);
    repeat (3) @(negedge clk);

    // start held high: back-to-back frames with one idle cycle between
    send_frame(0, 8'hFF, 1'b1, 0);
    send_frame(0, 8'hFF, 1'b1, 0);
    send_frame(0, 8'hFF, 1'b1, 0);
    st[0] = 1'b0;
    @(negedge clk);
    check("b2b release idle busy", busy_w[0], 1'b0);

    // reset at cycle 70 of a frame
    st[0]  = 1'b1;
    dat[0] = 8'h55;
    @(posedge clk);
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      st[0] = 1'b0;
      check($sformatf("pre-abort txd c%0d", k), txd_w[0], model_bit(8'h55, 0, k));
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort txd", txd_w[0], 1'b1);
    check("abort busy", busy_w[0], 1'b0);
    check("abort end", end_w[0], 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("in-rst end %0d", k), end_w[0], 1'b0);
      check($sformatf("in-rst txd %0d", k), txd_w[0], 1'b1);
    end
    rst_n = 1'b1;
    send_frame(0, 8'($urandom), 1'b0, 0);

    // randomized bytes on every configuration
    for (int r = 0; r < 3; r++)
      for (int u = 0; u < NU; u++) begin
        send_frame(u, 8'($urandom), 1'b0, 0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
